// File: rtl/tt_um_template_core_if.sv
// Tiny-tapeout user pin bundle: enable, dedicated in/out pins and bidirectional pins.
interface tt_um_template_core_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_template_core.sv
// Prescaled 0-9 decimal counter driving a 7-segment display; segments decode digit with no added latency.
// No backpressure: ena=0 freezes all state, ui_in[0] pauses and ui_in[2] clears synchronously.
module tt_um_template_core #(
  parameter int MAX_COUNT = 10_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tt_um_template_core_if.slave io
);

  localparam logic [23:0] LAST = 24'(MAX_COUNT - 1);

  logic [23:0] presc;
  logic [3:0]  digit;
  logic [3:0]  digit_next;
  logic [6:0]  seg;
  logic        unused_ok;

  // Direction is only consumed on the tick edge, so a mid-period change leaves presc alone.
  always_comb begin
    digit_next = digit;
    if (io.ui_in[1]) begin
      digit_next = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
    end else begin
      digit_next = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      digit <= '0;
    end else if (io.ena) begin
      if (io.ui_in[2]) begin
        presc <= '0;
        digit <= '0;
      end else if (!io.ui_in[0]) begin
        if (presc == LAST) begin
          presc <= '0;
          digit <= digit_next;
        end else begin
          presc <= presc + 24'd1;
        end
      end
    end
  end

  always_comb begin
    seg = 7'h00;
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

  assign io.uo_out  = {digit[0], seg};
  assign io.uio_out = 8'h00;
  assign io.uio_oe  = 8'h00;

  assign unused_ok = &{1'b0, io.uio_in, io.ui_in[7:3], 1'b0};

endmodule

// File: tb/tb_tt_um_template_core.sv
// Directed-vector bench for tt_um_template_core with MAX_COUNT=10.
module tb_tt_um_template_core;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tt_um_template_core_if io ();

  tt_um_template_core #(.MAX_COUNT(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected display byte {dp, segments} for digits 0..9, computed by hand.
  logic [7:0] glyph [10];
  initial begin
    glyph[0] = 8'h3F; glyph[1] = 8'h86; glyph[2] = 8'h5B; glyph[3] = 8'hCF;
    glyph[4] = 8'h66; glyph[5] = 8'hED; glyph[6] = 8'h7D; glyph[7] = 8'h87;
    glyph[8] = 8'h7F; glyph[9] = 8'hEF;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    io.ena    = 1'b1;
    io.ui_in  = 8'h00;
    io.uio_in = 8'hA5;

    // Reset state
    cycles(5);
    check("rst_uo", io.uo_out, 8'h3F);
    check("rst_oe", io.uio_oe, 8'h00);
    check("rst_uio_out", io.uio_out, 8'h00);

    // Count up through a full cycle and wrap
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycles(9);
      check($sformatf("up_hold%0d", i), io.uo_out, glyph[i]);
      cycles(1);
      check($sformatf("up_step%0d", i), io.uo_out, glyph[(i + 1) % 10]);
    end
    check("run_oe", io.uio_oe, 8'h00);
    check("run_uio_out", io.uio_out, 8'h00);

    // Count down from reset
    rst_n = 1'b0;
    io.ui_in = 8'h02;
    cycles(2);
    rst_n = 1'b1;
    cycles(9);
    check("dn_hold0", io.uo_out, glyph[0]);
    cycles(1);
    check("dn_9", io.uo_out, glyph[9]);
    cycles(10);
    check("dn_8", io.uo_out, glyph[8]);

    // Pause at digit 3 with presc=4, then resume
    rst_n = 1'b0;
    io.ui_in = 8'h00;
    cycles(2);
    rst_n = 1'b1;
    cycles(34);
    io.ui_in = 8'h01;
    cycles(50);
    check("pause_hold", io.uo_out, glyph[3]);
    io.ui_in = 8'h00;
    cycles(5);
    check("resume_hold", io.uo_out, glyph[3]);
    cycles(1);
    check("resume_4", io.uo_out, glyph[4]);

    // Clear pulse mid-period, then a full period to the next change
    cycles(3);
    io.ui_in = 8'h04;
    cycles(1);
    check("clr", io.uo_out, glyph[0]);
    io.ui_in = 8'h00;
    cycles(9);
    check("clr_hold", io.uo_out, glyph[0]);
    cycles(1);
    check("clr_next", io.uo_out, glyph[1]);

    // Clear while paused, and clear coincident with a tick
    cycles(4);
    io.ui_in = 8'h05;
    cycles(1);
    check("clr_paused", io.uo_out, glyph[0]);
    io.ui_in = 8'h00;
    cycles(9);
    io.ui_in = 8'h04;
    cycles(1);
    check("clr_vs_tick", io.uo_out, glyph[0]);
    io.ui_in = 8'h00;

    // Enable low freezes presc and digit
    cycles(5);
    io.ena = 1'b0;
    cycles(30);
    check("ena_frozen", io.uo_out, glyph[0]);
    io.ena = 1'b1;
    cycles(4);
    check("ena_hold", io.uo_out, glyph[0]);
    cycles(1);
    check("ena_resume", io.uo_out, glyph[1]);

    // Direction change mid-period keeps presc phase
    cycles(5);
    io.ui_in = 8'h02;
    cycles(4);
    check("dir_hold", io.uo_out, glyph[1]);
    cycles(1);
    check("dir_0", io.uo_out, glyph[0]);
    cycles(10);
    check("dir_wrap9", io.uo_out, glyph[9]);
    io.ui_in = 8'h00;

    // Async reset between edges at digit 7
    cycles(80);
    check("at_7", io.uo_out, glyph[7]);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", io.uo_out, 8'h3F);
    cycles(1);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_um_template_core.md
Name: tt_um_template_core

Overview:
- Seven-segment decimal counter tile with the standard tiny-tapeout user-module pinout.
- An internal prescaler divides the clock down to a "tick".
- Each tick steps a 0-9 digit register.
- The digit is decoded onto uo_out[6:0] to drive a 7-segment display directly.

Parameters:
- MAX_COUNT, 10_000_000, clock cycles per digit step (1 s at 10 MHz); legal range 2 to 2^24-1; benches override it with a small value such as 10.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  tile enable; 0 freezes all state
- ui_in  input  8  control: [0] pause, [1] count down, [2] synchronous clear, [7:3] ignored
- uo_out  output  8  [6:0] segments a..g (bit0=a … bit6=g, active-high), [7] decimal point
- uio_in  input  8  unused, ignored
- uio_out  output  8  constant 0
- uio_oe  output  8  constant 0 (all bidirectionals are inputs)

Behaviour:
- Single clock domain.
- Reset is asynchronous and active-low on rst_n: assertion immediately forces presc=0 and digit=0.
  - Consequently uo_out = 0x3F (the "0" glyph, dp=0).
  - Release is synchronous to the next rising edge.
- State registers:
  - presc: 24-bit prescaler.
  - digit: 4-bit, holding 0..9 only.
- Per rising edge, first matching rule wins:
  1. ena=0: hold everything.
  2. ui_in[2]=1 (clear): presc<=0, digit<=0.
  3. ui_in[0]=1 (pause): hold presc and digit.
  4. presc==MAX_COUNT-1: presc<=0 and digit steps, all on the same edge (tick).
  5. Otherwise presc<=presc+1.
- Digit step direction:
  - ui_in[1]=0: up, 9 wraps to 0.
  - ui_in[1]=1: down, 0 wraps to 9.
  - Direction is sampled on the tick edge only.
- Tick timing: after reset release with ena=1 and ui_in=0, the first digit change occurs on the MAX_COUNT-th rising edge. Every later change occurs exactly MAX_COUNT edges after the previous one.
- Segment decode is combinational from digit (no extra latency); hex values on uo_out[6:0]:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
- Illegal digit values 10-15 are unreachable; the decoder outputs 0x00 for them.
- uo_out[7] (decimal point) = digit[0], i.e. lit on odd digits.
- Pause releases resume from the held presc value; no tick is lost or duplicated.
- Direction changes mid-period take effect on the next tick without disturbing presc.
- Clear while paused still clears.
- Clear and tick coincident: clear wins.
- Outputs contain no X after reset; uio_out and uio_oe are 0 at all times.

Test Plan:
- Reset: MAX_COUNT=10, rst_n=0 for 5 cycles, ui_in=0, ena=1 -> uo_out[6:0]=0x3F, uo_out[7]=0, uio_oe=0 throughout.
- Count up: release reset, run 100 cycles.
  - uo_out[6:0] sequence 0x3F,06,5B,4F,66,6D,7D,07,7F,6F, each held exactly 10 cycles.
  - Then wraps back to 0x3F.
  - dp toggles with odd digits.
- Count down: ui_in=0x02 from reset -> after 10 cycles 0x6F (9), after 20 cycles 0x7F (8).
- Pause and clear:
  - Count to digit 3, set ui_in=0x01 for 50 cycles -> output stays 0x4F.
  - Release -> digit 4 appears after the remaining prescaler cycles only.
  - Pulse ui_in=0x04 for one cycle -> 0x3F next edge, next change 10 cycles later.
- Async reset mid-count: at digit 7, assert rst_n=0 between clock edges -> uo_out becomes 0x3F without waiting for a clock edge.
- Enable: ena=0 for 30 cycles mid-count -> digit and prescaler frozen; resumes exactly where left when ena=1.
